// File: rtl/commit_sched.sv
// commit_sched: in-order commit window for out-of-order completion.
// Allocates tags at tail, captures CDB results, retires from head.
module commit_sched #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             is_valid,
  input  logic [4:0]       is_dest,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_en,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_rdy,
  output logic             q2_rdy,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             commit_sgn,
  output logic [4:0]       commit_dest,
  output logic [31:0]      commit_value,
  output logic [TAG_W-1:0] commit_tag,
  input  logic             flush
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] ready_q;
  logic [4:0]       dest_q  [DEPTH];
  logic [31:0]      value_q [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             cdb_hit;

  // Handshake: rename wins over retire when both want the RF port.
  always_comb begin
    full       = (count_q == DEPTH_C);
    alloc_en   = is_valid & ~full & rdy & ~flush & ~rst;
    commit_sgn = busy_q[head_q] & ready_q[head_q] & rdy
               & ~flush & ~alloc_en & ~rst;
    cdb_hit    = cdb_valid & rdy & ~flush & busy_q[cdb_tag];
    alloc_tag    = tail_q;
    commit_tag   = head_q;
    commit_dest  = dest_q[head_q];
    commit_value = value_q[head_q];
  end

  // Operand lookup with same-cycle CDB forwarding.
  always_comb begin
    q1_rdy = 1'b0;
    q1_val = '0;
    q2_rdy = 1'b0;
    q2_val = '0;
    if (cdb_valid && cdb_tag == q1_tag) begin
      q1_rdy = 1'b1;
      q1_val = cdb_value;
    end else if (busy_q[q1_tag] && ready_q[q1_tag]) begin
      q1_rdy = 1'b1;
      q1_val = value_q[q1_tag];
    end
    if (cdb_valid && cdb_tag == q2_tag) begin
      q2_rdy = 1'b1;
      q2_val = cdb_value;
    end else if (busy_q[q2_tag] && ready_q[q2_tag]) begin
      q2_rdy = 1'b1;
      q2_val = value_q[q2_tag];
    end
  end

  // Pointer and occupancy next state; flush empties the window.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_en) begin
        tail_d  = tail_q + 1'b1;
        count_d = count_q + 1'b1;
      end
      if (commit_sgn) begin
        head_d  = head_q + 1'b1;
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer registers; frozen while rdy is low unless flushing.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy || flush) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry state: allocate at tail, complete via CDB, retire at head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      if (cdb_hit) begin
        ready_q[cdb_tag] <= 1'b1;
        value_q[cdb_tag] <= cdb_value;
      end
      if (alloc_en) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        dest_q[tail_q]  <= is_dest;
      end
      if (commit_sgn) begin
        busy_q[head_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_commit_sched.sv
// tb_commit_sched: directed scenarios plus random traffic checked
// against an ordered-queue model of the commit window.
module tb_commit_sched;

  logic        clk = 1'b0;
  logic        rst, rdy, is_valid, cdb_valid, flush;
  logic [4:0]  is_dest;
  logic [2:0]  alloc_tag, cdb_tag, q1_tag, q2_tag, commit_tag;
  logic        alloc_en, full, q1_rdy, q2_rdy, commit_sgn;
  logic [31:0] cdb_value, q1_val, q2_val, commit_value;
  logic [4:0]  commit_dest;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  dest;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t mq[$];
  int   hd = 0;

  always #5 clk = ~clk;

  commit_sched #(.DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_valid(is_valid), .is_dest(is_dest),
    .alloc_tag(alloc_tag), .alloc_en(alloc_en), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_rdy(q1_rdy), .q2_rdy(q2_rdy),
    .q1_val(q1_val), .q2_val(q2_val),
    .commit_sgn(commit_sgn), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .flush(flush)
  );

  task automatic chk(input string tg, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tg, obs, exp);
    end
  endtask

  // Position of a tag inside the in-flight window (-1 if not busy).
  function automatic int pos(input logic [2:0] t);
    int k;
    k = (int'(t) - hd + 8) % 8;
    return (k < mq.size()) ? k : -1;
  endfunction

  function automatic logic [32:0] look(input logic [2:0] t);
    int k;
    if (cdb_valid && cdb_tag == t) return {1'b1, cdb_value};
    k = pos(t);
    if (k >= 0 && mq[k].done) return {1'b1, mq[k].val};
    return 33'd0;
  endfunction

  task automatic cyc();
    int   n;
    bit   ea, ec;
    logic [32:0] l1, l2;
    int   k;
    #1;
    n  = mq.size();
    ea = !rst && is_valid && (n != 8) && rdy && !flush;
    ec = !rst && n > 0 && mq[0].done && rdy && !flush && !ea;
    l1 = look(q1_tag);
    l2 = look(q2_tag);
    chk("alloc_en", 32'(alloc_en), 32'(ea));
    chk("alloc_tag", 32'(alloc_tag), 32'((hd + n) % 8));
    chk("full", 32'(full), 32'(n == 8));
    chk("commit_sgn", 32'(commit_sgn), 32'(ec));
    chk("commit_tag", 32'(commit_tag), 32'(hd));
    if (ec) begin
      chk("commit_dest", 32'(commit_dest), 32'(mq[0].dest));
      chk("commit_value", commit_value, mq[0].val);
    end
    chk("q1_rdy", 32'(q1_rdy), 32'(l1[32]));
    chk("q1_val", q1_val, l1[31:0]);
    chk("q2_rdy", 32'(q2_rdy), 32'(l2[32]));
    chk("q2_val", q2_val, l2[31:0]);
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
      hd = 0;
    end else if (rdy) begin
      k = pos(cdb_tag);
      if (cdb_valid && k >= 0) begin
        mq[k].done = 1'b1;
        mq[k].val  = cdb_value;
      end
      if (ea) mq.push_back('{dest: is_dest, done: 1'b0, val: 32'd0});
      if (ec) begin
        void'(mq.pop_front());
        hd = (hd + 1) % 8;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rdy = 1; flush = 0;
    is_valid = 0; cdb_valid = 0;
  endtask

  task automatic alloc(input logic [4:0] d);
    idle();
    is_valid = 1;
    is_dest  = d;
    cyc();
  endtask

  task automatic done(input logic [2:0] t, input logic [31:0] v);
    idle();
    cdb_valid = 1;
    cdb_tag   = t;
    cdb_value = v;
    cyc();
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    cyc();
  endtask

  initial begin
    idle();
    rst = 1; is_dest = 0; cdb_tag = 0; cdb_value = 0;
    q1_tag = 0; q2_tag = 0;
    repeat (2) @(negedge clk);
    cyc();
    idle();
    cyc();

    // In-order commit despite out-of-order completion.
    alloc(5); alloc(6); alloc(7);
    done(2, 32'h22); done(0, 32'h10); done(1, 32'h11);
    repeat (3) begin idle(); cyc(); end

    // Fill, overflow attempt, retire one, wrap to tag 0.
    do_flush();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1));
    chk("full_after_8", 32'(full), 32'd1);
    alloc(9);
    done(0, 32'hA0);
    idle(); cyc();
    chk("full_after_commit", 32'(full), 32'd0);
    chk("wrap_tag", 32'(alloc_tag), 32'd0);
    alloc(10);

    // Allocation beats commit in the same cycle.
    do_flush();
    alloc(3);
    done(0, 32'h33);
    alloc(4);
    idle(); cyc();

    // Same-cycle CDB bypass on lookup.
    do_flush();
    for (int i = 0; i < 4; i++) alloc(5'(i + 11));
    idle();
    q1_tag = 3; cdb_valid = 1; cdb_tag = 3; cdb_value = 32'hDEADBEEF;
    #1;
    chk("bypass_rdy", 32'(q1_rdy), 32'd1);
    chk("bypass_val", q1_val, 32'hDEADBEEF);
    cyc();
    done(1, 32'h77);
    idle(); q1_tag = 1; q2_tag = 3; cyc();
    idle(); flush = 1; cyc();
    idle(); cyc();

    // Stall with a ready head, then release.
    alloc(20);
    done(0, 32'h55);
    repeat (3) begin idle(); rdy = 0; cyc(); end
    idle(); cyc();

    // Reset mid-operation with a ready head.
    alloc(21); alloc(22);
    done(1, 32'h66);
    idle(); rst = 1; cyc();
    idle(); cyc();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      rdy       = ($urandom_range(0, 99) < 85);
      flush     = rdy && ($urandom_range(0, 39) == 0);
      is_valid  = $urandom_range(0, 1);
      is_dest   = 5'($urandom);
      cdb_valid = $urandom_range(0, 1);
      cdb_tag   = 3'($urandom);
      cdb_value = $urandom;
      q1_tag    = 3'($urandom);
      q2_tag    = 3'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
